// File: rtl/arm_pkg.sv
// Shared ARM7 data-path constants for the operand shifter stage.
//   - shift-type encodings (instruction bits [6:5])
//   - operand B source select encodings
//   - data-processing opcodes (instruction bits [24:21])
//   - operand shifter stage FSM state type
package arm_pkg;

  localparam logic [1:0] SHIFT_LSL = 2'd0;
  localparam logic [1:0] SHIFT_LSR = 2'd1;
  localparam logic [1:0] SHIFT_ASR = 2'd2;
  localparam logic [1:0] SHIFT_ROR = 2'd3;

  localparam logic [1:0] OPB_IMM     = 2'd0;
  localparam logic [1:0] OPB_REG_IMM = 2'd1;
  localparam logic [1:0] OPB_REG_REG = 2'd2;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_EOR = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_RSB = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_ADC = 4'd5;
  localparam logic [3:0] OP_SBC = 4'd6;
  localparam logic [3:0] OP_RSC = 4'd7;
  localparam logic [3:0] OP_TST = 4'd8;
  localparam logic [3:0] OP_TEQ = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_CMN = 4'd11;
  localparam logic [3:0] OP_ORR = 4'd12;
  localparam logic [3:0] OP_MOV = 4'd13;
  localparam logic [3:0] OP_BIC = 4'd14;
  localparam logic [3:0] OP_MVN = 4'd15;

  typedef enum logic [1:0] {
    StIdle,
    StShiftWait,
    StFull
  } stage_state_e;

endpackage

// File: rtl/barrel_shifter_core.sv
// Combinational ARM7 barrel shifter.
//   value      : operand to shift
//   amount     : shift amount (imm form uses [4:0] only; reg form uses all 8 bits)
//   shift_type : LSL/LSR/ASR/ROR
//   imm_form   : 1 = immediate-amount semantics (#0 encodes LSR/ASR #32, RRX)
//   carry_in   : current C flag
//   result     : shifted value
//   carry      : shifter carry-out
module barrel_shifter_core
  import arm_pkg::*;
(
  input  logic [31:0] value,
  input  logic [7:0]  amount,
  input  logic [1:0]  shift_type,
  input  logic        imm_form,
  input  logic        carry_in,
  output logic [31:0] result,
  output logic        carry
);

  logic [4:0]  n;
  logic [4:0]  n_m1;
  logic [4:0]  n_lsl;
  logic [31:0] lsl_v;
  logic [31:0] lsr_v;
  logic [31:0] asr_v;
  logic [31:0] rot_v;
  logic        big;
  logic        eq32;

  assign n     = amount[4:0];
  assign n_m1  = n - 5'd1;
  // 32 - n modulo 32; only used for n in 1..31, where it is exact.
  assign n_lsl = 5'd0 - n;
  assign lsl_v = value << n;
  assign lsr_v = value >> n;
  assign asr_v = 32'($signed(value) >>> n);
  assign rot_v = (value >> n) | (value << n_lsl);
  assign big   = (amount[7:5] != 3'd0);
  assign eq32  = (amount == 8'd32);

  always_comb begin
    result = value;
    carry  = carry_in;
    if (imm_form) begin
      unique case (shift_type)
        SHIFT_LSL: begin
          if (n != 5'd0) begin
            result = lsl_v;
            carry  = value[n_lsl];
          end
        end
        SHIFT_LSR: begin
          if (n == 5'd0) begin
            result = '0;
            carry  = value[31];
          end else begin
            result = lsr_v;
            carry  = value[n_m1];
          end
        end
        SHIFT_ASR: begin
          if (n == 5'd0) begin
            result = {32{value[31]}};
            carry  = value[31];
          end else begin
            result = asr_v;
            carry  = value[n_m1];
          end
        end
        default: begin
          if (n == 5'd0) begin
            // RRX
            result = {carry_in, value[31:1]};
            carry  = value[0];
          end else begin
            result = rot_v;
            carry  = value[n_m1];
          end
        end
      endcase
    end else if (amount != 8'd0) begin
      unique case (shift_type)
        SHIFT_LSL: begin
          if (big) begin
            result = '0;
            carry  = eq32 ? value[0] : 1'b0;
          end else begin
            result = lsl_v;
            carry  = value[n_lsl];
          end
        end
        SHIFT_LSR: begin
          if (big) begin
            result = '0;
            carry  = eq32 ? value[31] : 1'b0;
          end else begin
            result = lsr_v;
            carry  = value[n_m1];
          end
        end
        SHIFT_ASR: begin
          if (big) begin
            result = {32{value[31]}};
            carry  = value[31];
          end else begin
            result = asr_v;
            carry  = value[n_m1];
          end
        end
        default: begin
          // Nonzero multiple of 32: value unchanged, carry is the top bit.
          if (n == 5'd0) begin
            carry = value[31];
          end else begin
            result = rot_v;
            carry  = value[n_m1];
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/operand_shifter_stage.sv
// Pipeline stage in front of the ALU: registers opcode and Rn, builds operand B
// (rotated immediate or shifted Rm) and the shifter carry-out.
//   clk, reset                 : clock, async active-high reset
//   in_valid / in_ready        : upstream handshake
//   alu_control_in, operand_a_in : passed through
//   rm_value, rs_value, imm8, imm_rot, shift_type, shift_imm, op_sel, carry_in : operand B controls
//   flush                      : drop in-flight content
//   out_valid / out_ready      : ALU-side handshake
//   alu_control, operand_a, operand_b, shifter_carry : registered results
module operand_shifter_stage
  import arm_pkg::*;
#(
  parameter bit REG_SHIFT_EXTRA_CYCLE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_control_in,
  input  logic [31:0] operand_a_in,
  input  logic [31:0] rm_value,
  input  logic [31:0] rs_value,
  input  logic [7:0]  imm8,
  input  logic [3:0]  imm_rot,
  input  logic [1:0]  shift_type,
  input  logic [4:0]  shift_imm,
  input  logic [1:0]  op_sel,
  input  logic        carry_in,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_control,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic        shifter_carry
);

  stage_state_e state_q, state_d;

  logic [3:0]  alu_control_q;
  logic [31:0] operand_a_q, operand_b_q;
  logic        shifter_carry_q;

  // Operands held across the extra register-shift cycle.
  logic [31:0] cap_rm_q, cap_rn_q;
  logic [7:0]  cap_rs_q;
  logic [1:0]  cap_type_q;
  logic [3:0]  cap_op_q;
  logic        cap_c_q;

  logic        accept;
  logic        defer;
  logic        load_out;
  logic        in_wait;

  logic [31:0] sh_value;
  logic [7:0]  sh_amount;
  logic [1:0]  sh_type;
  logic        sh_imm_form;
  logic        sh_carry_in;
  logic [31:0] sh_result;
  logic        sh_carry;

  assign in_wait  = (state_q == StShiftWait);
  assign in_ready = (state_q == StIdle) || ((state_q == StFull) && out_ready);
  assign accept   = in_valid && in_ready;
  assign defer    = REG_SHIFT_EXTRA_CYCLE && (op_sel == OPB_REG_REG);
  assign load_out = !flush && ((accept && !defer) || in_wait);

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) state_d = defer ? StShiftWait : StFull;
        end
        StShiftWait: state_d = StFull;
        default: begin
          if (accept) state_d = defer ? StShiftWait : StFull;
          else if (out_ready) state_d = StIdle;
        end
      endcase
    end
  end

  // One shifter serves every form; the waiting register shift takes priority.
  always_comb begin
    sh_value    = rm_value;
    sh_amount   = {3'b0, shift_imm};
    sh_type     = shift_type;
    sh_imm_form = 1'b1;
    sh_carry_in = carry_in;
    if (in_wait) begin
      sh_value    = cap_rm_q;
      sh_amount   = cap_rs_q;
      sh_type     = cap_type_q;
      sh_imm_form = 1'b0;
      sh_carry_in = cap_c_q;
    end else if (op_sel == OPB_IMM) begin
      // Register-form ROR by 2*rot gives the immediate carry rule for free.
      sh_value    = {24'b0, imm8};
      sh_amount   = {3'b0, imm_rot, 1'b0};
      sh_type     = SHIFT_ROR;
      sh_imm_form = 1'b0;
    end else if (op_sel == OPB_REG_REG) begin
      sh_amount   = rs_value[7:0];
      sh_imm_form = 1'b0;
    end
  end

  barrel_shifter_core u_shifter (
    .value      (sh_value),
    .amount     (sh_amount),
    .shift_type (sh_type),
    .imm_form   (sh_imm_form),
    .carry_in   (sh_carry_in),
    .result     (sh_result),
    .carry      (sh_carry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      alu_control_q   <= '0;
      operand_a_q     <= '0;
      operand_b_q     <= '0;
      shifter_carry_q <= 1'b0;
      cap_rm_q        <= '0;
      cap_rn_q        <= '0;
      cap_rs_q        <= '0;
      cap_type_q      <= '0;
      cap_op_q        <= '0;
      cap_c_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_out) begin
        alu_control_q   <= in_wait ? cap_op_q : alu_control_in;
        operand_a_q     <= in_wait ? cap_rn_q : operand_a_in;
        operand_b_q     <= sh_result;
        shifter_carry_q <= sh_carry;
      end
      if (!flush && accept && defer) begin
        cap_rm_q   <= rm_value;
        cap_rn_q   <= operand_a_in;
        cap_rs_q   <= rs_value[7:0];
        cap_type_q <= shift_type;
        cap_op_q   <= alu_control_in;
        cap_c_q    <= carry_in;
      end
    end
  end

  assign out_valid     = (state_q == StFull);
  assign alu_control   = alu_control_q;
  assign operand_a     = operand_a_q;
  assign operand_b     = operand_b_q;
  assign shifter_carry = shifter_carry_q;

endmodule

// File: tb/tb_operand_shifter_stage.sv
module tb_operand_shifter_stage;
  import arm_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control_in;
  logic [31:0] operand_a_in;
  logic [31:0] rm_value;
  logic [31:0] rs_value;
  logic [7:0]  imm8;
  logic [3:0]  imm_rot;
  logic [1:0]  shift_type;
  logic [4:0]  shift_imm;
  logic [1:0]  op_sel;
  logic        carry_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_control;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        shifter_carry;

  int checks = 0;
  int errors = 0;

  operand_shifter_stage #(.REG_SHIFT_EXTRA_CYCLE(1'b1)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .alu_control_in (alu_control_in),
    .operand_a_in   (operand_a_in),
    .rm_value       (rm_value),
    .rs_value       (rs_value),
    .imm8           (imm8),
    .imm_rot        (imm_rot),
    .shift_type     (shift_type),
    .shift_imm      (shift_imm),
    .op_sel         (op_sel),
    .carry_in       (carry_in),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .alu_control    (alu_control),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .shifter_carry  (shifter_carry)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] sel, input logic [1:0] typ, input logic [31:0] rm,
                        input logic [31:0] rs, input logic [4:0] simm, input logic [7:0] i8,
                        input logic [3:0] irot, input logic c, input logic [3:0] op,
                        input logic [31:0] rn);
    op_sel = sel; shift_type = typ; rm_value = rm; rs_value = rs; shift_imm = simm;
    imm8 = i8; imm_rot = irot; carry_in = c; alu_control_in = op; operand_a_in = rn;
  endtask

  // Present the current inputs for exactly one (accepting) edge.
  task automatic pulse_valid();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    set_op(OPB_IMM, SHIFT_LSL, 32'h0, 32'h0, 5'd0, 8'h0, 4'h0, 1'b0, OP_AND, 32'h0);
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    checks++; if (operand_b !== 32'h0) begin errors++; $display("FAIL reset_b: got %h expected 0", operand_b); end
    checks++; if (operand_a !== 32'h0) begin errors++; $display("FAIL reset_a: got %h expected 0", operand_a); end
    checks++; if ({alu_control, shifter_carry} !== 5'h0) begin errors++; $display("FAIL reset_ctl: got %h/%b expected 0/0", alu_control, shifter_carry); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_lsl_imm();
    set_op(OPB_REG_IMM, SHIFT_LSL, 32'h9000_0001, 32'h0, 5'd4, 8'h0, 4'h0, 1'b0, OP_ORR, 32'h1234_5678);
    pulse_valid();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lsl_latency: out_valid got %b expected 1", out_valid); end
    checks++; if (operand_b !== 32'h0000_0010) begin errors++; $display("FAIL lsl_b: got %h expected 00000010", operand_b); end
    checks++; if (shifter_carry !== 1'b1) begin errors++; $display("FAIL lsl_c: got %b expected 1", shifter_carry); end
    checks++; if (alu_control !== OP_ORR || operand_a !== 32'h1234_5678) begin errors++; $display("FAIL lsl_pass: got %h/%h expected c/12345678", alu_control, operand_a); end
    drain();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lsl_drain: out_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_imm_rrx();
    set_op(OPB_IMM, SHIFT_LSL, 32'h0, 32'h0, 5'd0, 8'hFF, 4'd4, 1'b0, OP_MOV, 32'h0);
    pulse_valid();
    checks++; if (operand_b !== 32'hFF00_0000) begin errors++; $display("FAIL imm_b: got %h expected ff000000", operand_b); end
    checks++; if (shifter_carry !== 1'b1) begin errors++; $display("FAIL imm_c: got %b expected 1", shifter_carry); end
    drain();
    set_op(OPB_REG_IMM, SHIFT_ROR, 32'h0000_0003, 32'h0, 5'd0, 8'h0, 4'h0, 1'b1, OP_MOV, 32'h0);
    pulse_valid();
    checks++; if (operand_b !== 32'h8000_0001) begin errors++; $display("FAIL rrx_b: got %h expected 80000001", operand_b); end
    checks++; if (shifter_carry !== 1'b1) begin errors++; $display("FAIL rrx_c: got %b expected 1", shifter_carry); end
    drain();
  endtask

  task automatic test_shift_zero_forms();
    set_op(OPB_REG_IMM, SHIFT_LSR, 32'h8000_0000, 32'h0, 5'd0, 8'h0, 4'h0, 1'b0, OP_MOV, 32'h0);
    pulse_valid();
    checks++; if (operand_b !== 32'h0 || shifter_carry !== 1'b1) begin errors++; $display("FAIL lsr32: got %h/%b expected 00000000/1", operand_b, shifter_carry); end
    drain();
    set_op(OPB_REG_IMM, SHIFT_ASR, 32'h8000_0000, 32'h0, 5'd0, 8'h0, 4'h0, 1'b0, OP_MOV, 32'h0);
    pulse_valid();
    checks++; if (operand_b !== 32'hFFFF_FFFF || shifter_carry !== 1'b1) begin errors++; $display("FAIL asr32: got %h/%b expected ffffffff/1", operand_b, shifter_carry); end
    drain();
  endtask

  task automatic test_reg_shift();
    logic [1:0]  typ [4] = '{SHIFT_LSL, SHIFT_LSL, SHIFT_ROR, SHIFT_LSR};
    logic [31:0] rm  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h4000_0000, 32'h8000_0000};
    logic [31:0] rs  [4] = '{32'h21, 32'h100, 32'h20, 32'h20};
    logic        cin [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] expb[4] = '{32'h0, 32'hFFFF_FFFF, 32'h4000_0000, 32'h0};
    logic        expc[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      set_op(OPB_REG_REG, typ[i], rm[i], rs[i], 5'd0, 8'h0, 4'h0, cin[i], OP_AND, 32'hA5A5_0000 + i);
      pulse_valid();
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL reg_wait%0d: ready/valid got %b/%b expected 0/0", i, in_ready, out_valid); end
      carry_in = ~cin[i];  // C must come from the accept cycle
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL reg_latency%0d: out_valid got %b expected 1", i, out_valid); end
      checks++; if (operand_b !== expb[i] || shifter_carry !== expc[i]) begin errors++; $display("FAIL reg_result%0d: got %h/%b expected %h/%b", i, operand_b, shifter_carry, expb[i], expc[i]); end
      checks++; if (operand_a !== 32'hA5A5_0000 + i) begin errors++; $display("FAIL reg_rn%0d: got %h expected %h", i, operand_a, 32'hA5A5_0000 + i); end
      drain();
    end
  endtask

  task automatic test_back_to_back();
    set_op(OPB_REG_IMM, SHIFT_LSL, 32'h1, 32'h0, 5'd1, 8'h0, 4'h0, 1'b0, OP_ADD, 32'h11);
    pulse_valid();
    set_op(OPB_REG_IMM, SHIFT_LSL, 32'h1, 32'h0, 5'd2, 8'h0, 4'h0, 1'b0, OP_SUB, 32'h22);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d: got %b expected 0", i, in_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || operand_b !== 32'h2 || alu_control !== OP_ADD) begin errors++; $display("FAIL bp_hold%0d: got %b/%h/%h expected 1/00000002/4", i, out_valid, operand_b, alu_control); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || operand_b !== 32'h4 || operand_a !== 32'h22) begin errors++; $display("FAIL b2b_data: got %b/%h/%h expected 1/00000004/00000022", out_valid, operand_b, operand_a); end
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    set_op(OPB_REG_REG, SHIFT_LSR, 32'h0000_0100, 32'h4, 5'd0, 8'h0, 4'h0, 1'b0, OP_EOR, 32'h33);
    pulse_valid();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre: in_ready got %b expected 0", in_ready); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_state: valid/ready got %b/%b expected 0/1", out_valid, in_ready); end
    checks++; if (operand_b !== 32'h4 || operand_a !== 32'h22) begin errors++; $display("FAIL flush_keep: got %h/%h expected 00000004/00000022", operand_b, operand_a); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_idle: out_valid got %b expected 0", out_valid); end
    pulse_valid();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_next_wait: out_valid got %b expected 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || operand_b !== 32'h10 || shifter_carry !== 1'b0) begin errors++; $display("FAIL flush_next: got %b/%h/%b expected 1/00000010/0", out_valid, operand_b, shifter_carry); end
    drain();
  endtask

  task automatic test_async_reset();
    set_op(OPB_REG_IMM, SHIFT_ROR, 32'h0000_00FF, 32'h0, 5'd8, 8'h0, 4'h0, 1'b0, OP_MVN, 32'hDEAD_BEEF);
    pulse_valid();
    checks++; if (operand_b !== 32'hFF00_0000 || shifter_carry !== 1'b1) begin errors++; $display("FAIL ror8: got %h/%b expected ff000000/1", operand_b, shifter_carry); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || operand_b !== 32'h0 || operand_a !== 32'h0) begin errors++; $display("FAIL arst_data: got %b/%h/%h expected 0/0/0", out_valid, operand_b, operand_a); end
    checks++; if (alu_control !== 4'h0 || shifter_carry !== 1'b0) begin errors++; $display("FAIL arst_ctl: got %h/%b expected 0/0", alu_control, shifter_carry); end
    #1;
    reset = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL arst_idle: ready/valid got %b/%b expected 1/0", in_ready, out_valid); end
  endtask

  initial begin
    test_reset();
    test_lsl_imm();
    test_imm_rrx();
    test_shift_zero_forms();
    test_reg_shift();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_shifter_stage.md
Name: operand_shifter_stage

Overview:
- Pipeline stage directly upstream of the ALU.
- Registers the ALU opcode and operand A.
- Builds operand B from one of two sources, using ARM7TDMI data-processing semantics:
  - a rotated 8-bit immediate, or
  - a register shifted by an immediate amount or by a register amount.
- Produces the shifter carry-out used for C on logical ops.
- Register-specified shifts take one extra cycle, matching ARM7 timing.
- Valid/ready handshake on both sides; single-entry output register.

Parameters:
- REG_SHIFT_EXTRA_CYCLE, 1: 1 = register-specified shift costs one extra cycle; 0 = all forms single-cycle.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream request valid.
- in_ready  output  1  stage can accept this cycle.
- alu_control_in  input  4  data-processing opcode, passed through.
- operand_a_in  input  32  Rn value, passed through.
- rm_value  input  32  Rm value.
- rs_value  input  32  Rs value; only [7:0] used.
- imm8  input  8  immediate field.
- imm_rot  input  4  immediate rotate field.
- shift_type  input  2  LSL=0, LSR=1, ASR=2, ROR=3.
- shift_imm  input  5  immediate shift amount.
- op_sel  input  2  operand B source:
  - 0 = rotated immediate;
  - 1 = Rm shifted by immediate;
  - 2 = Rm shifted by Rs;
  - 3 = reserved, treated as 1.
- carry_in  input  1  current CPSR C.
- flush  input  1  discard all in-flight content.
- out_valid  output  1  ALU-side data valid.
- out_ready  input  1  ALU accepts this cycle.
- alu_control  output  4  registered opcode.
- operand_a  output  32  registered Rn.
- operand_b  output  32  shifted or rotated operand.
- shifter_carry  output  1  shifter carry-out.

Behaviour:
- Reset (asynchronous): state=IDLE, out_valid=0, operand_a=0, operand_b=0, alu_control=0, shifter_carry=0.
- Outputs are registered; they change only on an accepting clk edge, or on reset/flush.
- FSM states IDLE, SHIFT_WAIT, FULL.
- in_ready = (state==IDLE) || (state==FULL && out_ready). It is 0 in SHIFT_WAIT.
- Accept occurs when in_valid && in_ready. All inputs, including carry_in, are sampled at acceptance.
  - op_sel 0/1, or REG_SHIFT_EXTRA_CYCLE=0: result is registered and out_valid=1 on the next edge (latency 1). State becomes FULL.
  - op_sel 2 with REG_SHIFT_EXTRA_CYCLE=1: the sampled Rm, Rs[7:0], type, opcode, Rn and C are captured internally and state becomes SHIFT_WAIT. The next edge computes the result, sets out_valid=1 and moves to FULL (latency 2).
- In FULL with out_ready=0, all outputs hold stable.
- In FULL with out_ready=1 and no accept, state returns to IDLE and out_valid=0.
- In FULL with out_ready=1 and a simultaneous accept: back-to-back transfer, no bubble for latency-1 forms.
- flush has priority over every other event. On the next edge: state=IDLE, out_valid=0, the pending accept is dropped, and data registers keep their old values.
- Immediate form: B = imm8 rotated right by 2*imm_rot. Carry = carry_in if imm_rot==0, else B[31].
- Immediate shift, amount n = shift_imm:
  - LSL n=0: B=Rm, carry=carry_in.
  - LSL n>0: B=Rm<<n, carry=Rm[32-n].
  - LSR n=0 means LSR #32: B=0, carry=Rm[31].
  - ASR n=0 means ASR #32: B={32{Rm[31]}}, carry=Rm[31].
  - ROR n=0 means RRX: B={carry_in, Rm[31:1]}, carry=Rm[0].
  - Otherwise standard shift; carry is the last bit shifted out.
- Register shift, amount s = Rs[7:0]:
  - s=0: B=Rm, carry=carry_in, for every type.
  - LSL: s=32 gives B=0, carry=Rm[0]; s>32 gives B=0, carry=0.
  - LSR: s=32 gives B=0, carry=Rm[31]; s>32 gives B=0, carry=0.
  - ASR: s>=32 gives B={32{Rm[31]}}, carry=Rm[31].
  - ROR with s[4:0]=0 and s≠0: B=Rm, carry=Rm[31]. Otherwise rotate by s[4:0].
- All arithmetic is unsigned 32-bit; amounts are zero-extended.

Decomposition:
- Shared package arm_pkg:
  - shift-type constants SHIFT_LSL/LSR/ASR/ROR;
  - op_sel constants OPB_IMM, OPB_REG_IMM, OPB_REG_REG;
  - the 16 data-processing opcode constants: AND=0 … MVN=15, including ORR=12 and BIC=14;
  - FSM state encoding.
- Sub-module barrel_shifter_core: purely combinational. Inputs value, 8-bit amount, type, imm_form flag, carry_in. Outputs result and carry. Used for both the immediate and register paths.

Test Plan:
- LSL imm: rm=0x9000_0001, shift_imm=4, C=0 -> operand_b=0x0000_0010, shifter_carry=1, out_valid one cycle after accept.
- Immediate and RRX: imm8=0xFF, imm_rot=4 -> B=0xFF00_0000, carry=1. Then ROR #0 with rm=0x0000_0003, C=1 -> B=0x8000_0001, carry=1.
- LSR #0 with rm=0x8000_0000 -> B=0, carry=1. ASR #0 with rm=0x8000_0000 -> B=0xFFFF_FFFF, carry=1.
- Register shift: op_sel=2, rm=0xFFFF_FFFF, LSL, rs=0x21 -> in_ready=0 for one cycle, out_valid two cycles after accept, B=0, carry=0. Then rs=0x100 with C=1 -> B=Rm, carry=1.
- Backpressure: hold out_ready=0 for 3 cycles while in_valid=1 -> outputs stable and no second accept. Then raise out_ready -> back-to-back accept with no bubble.
- Flush and reset:
  - Flush asserted while in SHIFT_WAIT -> out_valid stays 0 and state returns to IDLE. The next accept completes normally.
  - Asynchronous reset pulsed mid-FULL -> out_valid=0 and all outputs 0 immediately, without waiting for a clock edge.
